// File: rtl/riscv_pkg.sv
// Shared riscv_core decode constants: opcodes, immediate format selects, NOP.
package riscv_pkg;

  localparam int unsigned RV_XLEN   = 32;
  localparam int unsigned OPC_W     = 7;
  localparam int unsigned IMM_SEL_W = 3;
  localparam int unsigned ILL_CNT_W = 8;

  // Base opcodes (inst[6:0])
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  // Immediate format selects shared with imm_gen
  localparam logic [IMM_SEL_W-1:0] IMM_I   = 3'd0;
  localparam logic [IMM_SEL_W-1:0] IMM_S   = 3'd1;
  localparam logic [IMM_SEL_W-1:0] IMM_B   = 3'd2;
  localparam logic [IMM_SEL_W-1:0] IMM_U   = 3'd3;
  localparam logic [IMM_SEL_W-1:0] IMM_J   = 3'd4;
  localparam logic [IMM_SEL_W-1:0] IMM_CSR = 3'd5;

  // addi x0, x0, 0
  localparam logic [RV_XLEN-1:0] NOP = 32'h0000_0013;

  // Decode result for one instruction
  typedef struct packed {
    logic [IMM_SEL_W-1:0] imm_sel;
    logic                 uses_imm;
    logic                 illegal;
  } imm_ctrl_t;

endpackage

// File: rtl/imm_sel_decode.sv
// Combinational opcode classifier: immediate format, immediate use, illegal flag.
module imm_sel_decode
  import riscv_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             funct3_msb,
  output imm_ctrl_t        ctrl_c
);

  // Opcode table; unknown opcodes flag illegal with no immediate
  always_comb begin
    ctrl_c = '{imm_sel: IMM_I, uses_imm: 1'b0, illegal: 1'b0};
    unique case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: ctrl_c = '{imm_sel: IMM_I, uses_imm: 1'b1, illegal: 1'b0};
      OPC_STORE:                      ctrl_c = '{imm_sel: IMM_S, uses_imm: 1'b1, illegal: 1'b0};
      OPC_BRANCH:                     ctrl_c = '{imm_sel: IMM_B, uses_imm: 1'b1, illegal: 1'b0};
      OPC_LUI, OPC_AUIPC:             ctrl_c = '{imm_sel: IMM_U, uses_imm: 1'b1, illegal: 1'b0};
      OPC_JAL:                        ctrl_c = '{imm_sel: IMM_J, uses_imm: 1'b1, illegal: 1'b0};
      OPC_SYSTEM: begin
        // CSRR*I forms carry a 5-bit zero-extended uimm in rs1
        if (funct3_msb) ctrl_c = '{imm_sel: IMM_CSR, uses_imm: 1'b1, illegal: 1'b0};
        else            ctrl_c = '{imm_sel: IMM_I,   uses_imm: 1'b0, illegal: 1'b0};
      end
      OPC_OP:                         ctrl_c = '{imm_sel: IMM_I, uses_imm: 1'b0, illegal: 1'b0};
      default:                        ctrl_c = '{imm_sel: IMM_I, uses_imm: 1'b0, illegal: 1'b1};
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: 2-entry skid buffer between fetch and execute,
// head-entry classification for imm_gen, flush sequencing, illegal counter.
module decode_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH_LOG2 = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_inst,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_inst,
  output logic [XLEN-1:0]      out_pc,
  output logic [IMM_SEL_W-1:0] imm_sel,
  output logic                 uses_imm,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] illegal_cnt
);

  typedef enum logic [DEPTH_LOG2:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e;

  occ_e                 state_q, state_d;
  logic [XLEN-1:0]      sec_inst, sec_pc;
  logic [XLEN-1:0]      sec_inst_d, sec_pc_d;
  logic [XLEN-1:0]      head_inst_d, head_pc_d;
  logic                 in_ready_d, out_valid_d;
  logic [ILL_CNT_W-1:0] illegal_cnt_d;
  logic                 accept, retire;
  imm_ctrl_t            head_ctrl_c;
  imm_ctrl_t            ctrl_d;

  assign accept = in_valid & in_ready;
  assign retire = out_valid & out_ready;

  // Classify the entry that will be head after this edge so decode outputs register alongside it
  imm_sel_decode u_imm_sel_decode (
    .opcode     (head_inst_d[OPC_W-1:0]),
    .funct3_msb (head_inst_d[14]),
    .ctrl_c     (head_ctrl_c)
  );

  // Next occupancy, buffer contents and registered outputs
  always_comb begin
    state_d       = state_q;
    head_inst_d   = out_inst;
    head_pc_d     = out_pc;
    sec_inst_d    = sec_inst;
    sec_pc_d      = sec_pc;
    illegal_cnt_d = illegal_cnt;
    ctrl_d        = '{imm_sel: IMM_I, uses_imm: 1'b0, illegal: 1'b0};

    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_d     = OCC_ONE;
            head_inst_d = in_inst;
            head_pc_d   = in_pc;
          end
        end
        OCC_ONE: begin
          if (accept && !retire) begin
            state_d    = OCC_TWO;
            sec_inst_d = in_inst;
            sec_pc_d   = in_pc;
          end else if (accept && retire) begin
            head_inst_d = in_inst;
            head_pc_d   = in_pc;
          end else if (retire) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // in_ready is low here, so only a retire can move the buffer
          if (retire) begin
            state_d     = OCC_ONE;
            head_inst_d = sec_inst;
            head_pc_d   = sec_pc;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end

    out_valid_d = (state_d != OCC_EMPTY);
    in_ready_d  = (state_d != OCC_TWO);
    if (out_valid_d) ctrl_d = head_ctrl_c;

    // Retires count even in a flush cycle
    if (retire && illegal && (illegal_cnt != {ILL_CNT_W{1'b1}}))
      illegal_cnt_d = illegal_cnt + ILL_CNT_W'(1);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OCC_EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_inst    <= XLEN'(NOP);
      out_pc      <= '0;
      sec_inst    <= XLEN'(NOP);
      sec_pc      <= '0;
      imm_sel     <= IMM_I;
      uses_imm    <= 1'b0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      state_q     <= state_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      out_inst    <= head_inst_d;
      out_pc      <= head_pc_d;
      sec_inst    <= sec_inst_d;
      sec_pc      <= sec_pc_d;
      imm_sel     <= ctrl_d.imm_sel;
      uses_imm    <= ctrl_d.uses_imm;
      illegal     <= ctrl_d.illegal;
      illegal_cnt <= illegal_cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: directed scenarios plus random traffic
// against a queue-based model of the decode buffer.
module tb_decode_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  imm_sel;
  logic        uses_imm;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  decode_ctrl #(.XLEN(32), .DEPTH_LOG2(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .imm_sel     (imm_sel),
    .uses_imm    (uses_imm),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model: FIFO of {inst, pc} holding at most two entries
  logic [63:0] q[$];
  int unsigned m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {illegal, uses_imm, imm_sel[2:0]} straight from the opcode table
  function automatic logic [4:0] ref_dec(input logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return {1'b0, 1'b1, 3'd0};
      7'b0100011:                         return {1'b0, 1'b1, 3'd1};
      7'b1100011:                         return {1'b0, 1'b1, 3'd2};
      7'b0110111, 7'b0010111:             return {1'b0, 1'b1, 3'd3};
      7'b1101111:                         return {1'b0, 1'b1, 3'd4};
      7'b1110011:                         return inst[14] ? {1'b0, 1'b1, 3'd5} : {1'b0, 1'b0, 3'd0};
      7'b0110011:                         return {1'b0, 1'b0, 3'd0};
      default:                            return {1'b1, 1'b0, 3'd0};
    endcase
  endfunction

  task automatic check_outputs();
    logic [4:0]  d;
    logic [63:0] h;
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      h = q[0];
      d = ref_dec(h[63:32]);
      check("out_inst", out_inst, h[63:32]);
      check("out_pc", out_pc, h[31:0]);
      check("imm_sel", 32'(imm_sel), 32'(d[2:0]));
      check("uses_imm", 32'(uses_imm), 32'(d[3]));
      check("illegal", 32'(illegal), 32'(d[4]));
    end else begin
      check("imm_sel_idle", 32'(imm_sel), 32'd0);
      check("uses_imm_idle", 32'(uses_imm), 32'd0);
      check("illegal_idle", 32'(illegal), 32'd0);
    end
    check("illegal_cnt", 32'(illegal_cnt), m_cnt);
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic        acc, ret;
    logic [4:0]  d;
    logic [63:0] h;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc = v && (q.size() < 2);
    ret = (q.size() > 0) && ordy;
    @(posedge clk);
    if (ret) begin
      h = q[0];
      d = ref_dec(h[63:32]);
      if (d[4] && m_cnt < 255) m_cnt++;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back({inst, pc});
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011};
    r = $urandom;
    if ($urandom_range(0, 4) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  logic [31:0] sweep [6];

  initial begin
    n_vec = 0; n_err = 0; m_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_inst", out_inst, 32'h0000_0013);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_imm_sel", 32'(imm_sel), 32'd0);
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs();

    // Immediate format sweep, back to back
    sweep = '{32'h0050_0093, 32'h0011_2023, 32'h0000_0463,
              32'h1234_50B7, 32'h0080_00EF, 32'h3400_D073};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, sweep[i], 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      check("sweep_sel", 32'(imm_sel), 32'(i));
      check("sweep_uses", 32'(uses_imm), 32'd1);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: third instruction waits until a slot frees
    step(1'b1, 32'h0000_0003, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0023, 32'h204, 1'b0, 1'b0);
    check("bp_full", 32'(in_ready), 32'd0);
    step(1'b1, 32'h0000_0063, 32'h208, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0063, 32'h208, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0063, 32'h208, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush while accepting: nothing survives
    step(1'b1, 32'h0000_0037, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h0000_006F, 32'h304, 1'b0, 1'b1);
    check("flush_empty", 32'(out_valid), 32'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Illegal counter saturation
    for (int i = 0; i < 261; i++) step(1'b1, 32'hFFFF_FFFF, 32'h400 + 32'(i), 1'b1, 1'b0);
    step(1'b1, 32'h0000_0033, 32'h800, 1'b1, 1'b0);
    check("sat_cnt", 32'(illegal_cnt), 32'd255);
    check("op_illegal", 32'(illegal), 32'd0);
    check("op_uses", 32'(uses_imm), 32'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset with two entries buffered
    step(1'b1, 32'h0000_0013, 32'h900, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0017, 32'h904, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_cnt", 32'(illegal_cnt), 32'd0);
    q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_inst(), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
Name: decode_ctrl

Overview:
Decode-stage controller for the riscv_core pipeline. It accepts instructions from fetch through a valid/ready handshake and buffers them in a 2-entry skid buffer. For the head entry it classifies the opcode and drives the immediate generator's 3-bit select plus the decode control bits. It sits between the fetch stage and the imm_gen/regfile/execute stage, and it owns stall and flush sequencing for decode.

Parameters:
XLEN, 32, width of instruction and PC words
DEPTH_LOG2, 1, log2 of skid buffer depth (fixed at 1 → 2 entries; other values unsupported)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  decode can accept this cycle
in_inst  in  XLEN  fetched instruction
in_pc  in  XLEN  PC of in_inst
flush  in  1  kill all buffered instructions (branch mispredict/trap)
out_valid  out  1  head entry valid toward execute
out_ready  in  1  execute accepts head entry
out_inst  out  XLEN  head instruction (also feeds imm_gen inst)
out_pc  out  XLEN  head PC
imm_sel  out  3  immediate format select to imm_gen
uses_imm  out  1  head instruction consumes an immediate operand
illegal  out  1  head opcode not recognised
illegal_cnt  out  8  saturating count of illegal instructions retired from decode

Behaviour:
- Reset (async, rst_n=0): occupancy=EMPTY, out_valid=0, in_ready=1, out_inst=0x00000013 (NOP), out_pc=0, imm_sel=0, uses_imm=0, illegal=0, illegal_cnt=0. Deassertion takes effect on the next clk edge.
- Occupancy FSM states EMPTY, ONE, TWO. Accept = in_valid&in_ready; retire = out_valid&out_ready.
- EMPTY: accept→ONE. ONE: accept&!retire→TWO; retire&!accept→EMPTY; both→ONE (new entry becomes head). TWO: retire→ONE (second entry promoted to head); accept is impossible.
- in_ready = (state!=TWO), registered, so there is no combinational path from out_ready to in_ready.
- Latency: an instruction accepted on edge N is visible on out_* after edge N (one cycle) when the buffer was EMPTY.
- Order is strictly FIFO; no entry is dropped or duplicated.
- flush: on the next edge state→EMPTY, out_valid=0. Any accept in the same cycle is discarded. Flush wins over simultaneous accept/retire; a retire in the flush cycle still counts toward illegal_cnt.
- imm_sel/uses_imm/illegal are a combinational decode of the head opcode (inst[6:0]):
  0000011 LOAD, 0010011 OP-IMM, 1100111 JALR → 0 (I), uses_imm=1
  0100011 STORE → 1 (S), uses_imm=1
  1100011 BRANCH → 2 (B), uses_imm=1
  0110111 LUI, 0010111 AUIPC → 3 (U), uses_imm=1
  1101111 JAL → 4 (J), uses_imm=1
  1110011 SYSTEM with funct3[2]=1 → 5 (CSR uimm), uses_imm=1; funct3[2]=0 → 0, uses_imm=0
  0110011 OP → 0, uses_imm=0
  other → 0, uses_imm=0, illegal=1
- When out_valid=0: imm_sel=0, uses_imm=0, illegal=0.
- illegal_cnt increments on retire of an entry with illegal=1 and saturates at 255.

Decomposition:
- Shared package riscv_pkg holds: opcode localparams (OPC_LOAD, OPC_STORE, …), IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4, IMM_CSR=5, and NOP=0x00000013. imm_gen is updated to use the same constants.
- One sub-module: imm_sel_decode, the purely combinational opcode→{imm_sel, uses_imm, illegal} decoder. It can be reused by a future compressed/dual-issue decoder.
- The skid buffer and FSM stay inline.

Test Plan:
- Reset mid-stream: load two entries (state TWO), pull rst_n low asynchronously between edges → out_valid=0, in_ready=1, illegal_cnt=0 immediately, without waiting for an edge.
- Format sweep, out_ready=1: feed 0x00500093, 0x00112023, 0x00000463, 0x123450B7, 0x008000EF, 0x3400D073 → imm_sel 0,1,2,3,4,5 in order, uses_imm=1 each, one per cycle, no bubbles.
- Backpressure: out_ready=0, stream 3 instructions → first two accepted, in_ready=0 after the second. Raise out_ready → all three emerge in order with no loss.
- Flush with simultaneous accept: state ONE, in_valid=1 and flush=1 in the same cycle → next cycle out_valid=0, state EMPTY, and the accepted instruction never appears.
- Illegal counting: retire 0xFFFFFFFF 260 times → illegal=1 on each head, illegal_cnt saturates at 255. Then 0x00000033 (OP) → illegal=0, uses_imm=0.
